// File: rtl/ex_mem_if.sv
`default_nettype none
// ============================================================================
// ex_mem_if : execute <-> memory pipeline boundary bundle
// Rev 1.0   : initial release
// ============================================================================
interface ex_mem_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0]  stall;
  logic [ADDR_W-1:0]   ex_wd;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic                ex_whilo;
  logic [2*DATA_W-1:0] hilo_i;
  logic [1:0]          cnt_i;
  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_whilo;
  logic [2*DATA_W-1:0] hilo_o;
  logic [1:0]          cnt_o;

  // Execute side / control unit.
  modport master (
    output stall, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o
  );

  // The pipeline register itself.
  modport slave (
    input  stall, ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// ex_mem : EX->MEM pipeline register with stall/bubble control and
//          multiply-accumulate intermediate state holding
// Rev 1.0 : initial release
// ============================================================================
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6
) (
  input  logic    clk,
  input  logic    rst,
  ex_mem_if.slave bus
);

  localparam int c_EX_BIT  = 3;
  localparam int c_MEM_BIT = 4;

  logic [ADDR_W-1:0]   r_mem_wd;
  logic                r_mem_wreg;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_mem_hi;
  logic [DATA_W-1:0]   r_mem_lo;
  logic                r_mem_whilo;
  logic [2*DATA_W-1:0] r_hilo;
  logic [1:0]          r_cnt;

  logic w_ex_stop;
  logic w_mem_stop;

  assign w_ex_stop  = bus.stall[c_EX_BIT];
  assign w_mem_stop = bus.stall[c_MEM_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_wd    <= '0;
      r_mem_wreg  <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_hi    <= '0;
      r_mem_lo    <= '0;
      r_mem_whilo <= 1'b0;
      r_hilo      <= '0;
      r_cnt       <= 2'd0;
    end else if (w_ex_stop && !w_mem_stop) begin
      // Execute frozen, memory still moving: push a NOP, keep MAC state.
      r_mem_wd    <= '0;
      r_mem_wreg  <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_hi    <= '0;
      r_mem_lo    <= '0;
      r_mem_whilo <= 1'b0;
      r_hilo      <= bus.hilo_i;
      r_cnt       <= bus.cnt_i;
    end else if (!w_ex_stop) begin
      r_mem_wd    <= bus.ex_wd;
      r_mem_wreg  <= bus.ex_wreg;
      r_mem_wdata <= bus.ex_wdata;
      r_mem_hi    <= bus.ex_hi;
      r_mem_lo    <= bus.ex_lo;
      r_mem_whilo <= bus.ex_whilo;
      r_hilo      <= '0;
      r_cnt       <= 2'd0;
    end else begin
      r_hilo      <= bus.hilo_i;
      r_cnt       <= bus.cnt_i;
    end
  end

  assign bus.mem_wd    = r_mem_wd;
  assign bus.mem_wreg  = r_mem_wreg;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_hi    = r_mem_hi;
  assign bus.mem_lo    = r_mem_lo;
  assign bus.mem_whilo = r_mem_whilo;
  assign bus.hilo_o    = r_hilo;
  assign bus.cnt_o     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// ============================================================================
// tb_ex_mem : directed bench for ex_mem with a slot-level reference model
// Rev 1.0   : initial release
// ============================================================================
module tb_ex_mem;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int STALL_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;

  ex_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus ();

  ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: what sits in the MEM slot and what MAC state is parked.
  typedef struct packed {
    logic [ADDR_W-1:0]   wd;
    logic                wreg;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                whilo;
    logic [2*DATA_W-1:0] hilo;
    logic [1:0]          cnt;
  } slot_t;

  slot_t m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
    end else begin
      slot_t nx;
      nx = m;
      if (bus.stall[3] == 1'b0) begin
        nx = '{bus.ex_wd, bus.ex_wreg, bus.ex_wdata, bus.ex_hi, bus.ex_lo,
               bus.ex_whilo, {2*DATA_W{1'b0}}, 2'd0};
      end else begin
        if (bus.stall[4] == 1'b0) nx = '0;
        nx.hilo = bus.hilo_i;
        nx.cnt  = bus.cnt_i;
      end
      m <= nx;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("mdl_wd",    64'(bus.mem_wd),    64'(m.wd));
      check("mdl_wreg",  64'(bus.mem_wreg),  64'(m.wreg));
      check("mdl_wdata", 64'(bus.mem_wdata), 64'(m.wdata));
      check("mdl_hi",    64'(bus.mem_hi),    64'(m.hi));
      check("mdl_lo",    64'(bus.mem_lo),    64'(m.lo));
      check("mdl_whilo", 64'(bus.mem_whilo), 64'(m.whilo));
      check("mdl_hilo",  bus.hilo_o,         m.hilo);
      check("mdl_cnt",   64'(bus.cnt_o),     64'(m.cnt));
    end
  end

  task automatic drive(input logic [5:0] st, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] hi, input logic [31:0] lo,
                       input logic whilo, input logic [63:0] hilo, input logic [1:0] cnt);
    bus.stall    = st;
    bus.ex_wd    = wd;
    bus.ex_wreg  = wreg;
    bus.ex_wdata = wdata;
    bus.ex_hi    = hi;
    bus.ex_lo    = lo;
    bus.ex_whilo = whilo;
    bus.hilo_i   = hilo;
    bus.cnt_i    = cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive(6'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_wd",    64'(bus.mem_wd),    64'd0);
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_hilo",  bus.hilo_o,         64'd0);
    rst = 1'b0;
    armed = 1'b1;

    // Asynchronous reset between edges.
    drive(6'b0, 5'd1, 1'b1, 32'h12345678, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    tick();
    check("pre_rst_wdata", 64'(bus.mem_wdata), 64'h12345678);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("async_rst_wreg",  64'(bus.mem_wreg),  64'd0);
    tick();
    check("rst_held_wdata", 64'(bus.mem_wdata), 64'd0);
    rst = 1'b0;

    // Advance.
    drive(6'b000000, 5'd3, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0);
    tick();
    check("adv_wd",    64'(bus.mem_wd),    64'd3);
    check("adv_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
    check("adv_hi",    64'(bus.mem_hi),    64'd1);
    check("adv_lo",    64'(bus.mem_lo),    64'd2);
    check("adv_whilo", 64'(bus.mem_whilo), 64'd1);

    // Bubble.
    drive(6'b001111, 5'd3, 1'b1, 32'hDEADBEEF, 32'h1, 32'h2, 1'b1, 64'h00000001_FFFFFFFE, 2'd1);
    tick();
    check("bub_wreg",  64'(bus.mem_wreg),  64'd0);
    check("bub_wd",    64'(bus.mem_wd),    64'd0);
    check("bub_wdata", 64'(bus.mem_wdata), 64'd0);
    check("bub_hilo",  bus.hilo_o,         64'h00000001_FFFFFFFE);
    check("bub_cnt",   64'(bus.cnt_o),     64'd1);

    // Hold.
    drive(6'b000000, 5'd7, 1'b1, 32'hA5A5A5A5, 32'h3, 32'h4, 1'b0, 64'h0, 2'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(6'b011111, 5'(i + 10), i[0], $urandom, $urandom, $urandom, ~i[0],
            {$urandom, $urandom}, 2'd1);
      tick();
      check("hold_wd",    64'(bus.mem_wd),    64'd7);
      check("hold_wdata", 64'(bus.mem_wdata), 64'hA5A5A5A5);
      check("hold_cnt",   64'(bus.cnt_o),     64'd1);
    end

    // Multiply-accumulate A then B.
    drive(6'b001111, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h0000000A_00000005, 2'd1);
    tick();
    check("maddA_hilo", bus.hilo_o,     64'h0000000A_00000005);
    check("maddA_cnt",  64'(bus.cnt_o), 64'd1);
    drive(6'b000000, 5'd0, 1'b0, 32'h0, 32'hB, 32'h6, 1'b1, 64'h0000000A_00000005, 2'd2);
    tick();
    check("maddB_hi",    64'(bus.mem_hi),    64'hB);
    check("maddB_lo",    64'(bus.mem_lo),    64'h6);
    check("maddB_whilo", 64'(bus.mem_whilo), 64'd1);
    check("maddB_hilo",  bus.hilo_o,         64'd0);
    check("maddB_cnt",   64'(bus.cnt_o),     64'd0);

    // Reset mid-sequence.
    drive(6'b001111, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h00000003_00000004, 2'd1);
    tick();
    check("mid_cnt_before", 64'(bus.cnt_o), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_cnt_rst",  64'(bus.cnt_o), 64'd0);
    check("mid_hilo_rst", bus.hilo_o,     64'd0);
    #2 rst = 1'b0;
    drive(6'b000000, 5'd9, 1'b1, 32'h11223344, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    tick();
    check("post_rst_wd",    64'(bus.mem_wd),    64'd9);
    check("post_rst_wdata", 64'(bus.mem_wdata), 64'h11223344);

    // stall[3]=0 with stall[4]=1 still advances; other stall bits ignored.
    drive(6'b010000, 5'd12, 1'b1, 32'h0BADF00D, 32'h0, 32'h0, 1'b0, 64'hFFFF, 2'd3);
    tick();
    check("odd_stall_wdata", 64'(bus.mem_wdata), 64'h0BADF00D);
    check("odd_stall_cnt",   64'(bus.cnt_o),     64'd0);
    drive(6'b100111, 5'd21, 1'b0, 32'hCAFEF00D, 32'h0, 32'h0, 1'b1, 64'hFFFF, 2'd3);
    tick();
    check("ign_bits_wd",    64'(bus.mem_wd),    64'd21);
    check("ign_bits_whilo", 64'(bus.mem_whilo), 64'd1);

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
